// File: rtl/cpu_trace_buffer_if.sv
// cpu_trace_buffer_if: sample, control and drain signals of the trace buffer
interface cpu_trace_buffer_if #(
    parameter int WORDSIZE = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int CHANNELS = 6,
    parameter int DEPTH = 16,
    parameter int CW = $clog2(DEPTH) + 1
);
    logic                         trace_arm;
    logic                         trace_mode;
    logic [WORDSIZE-1:0]          trace_trig_pc;
    logic [CW-1:0]                trace_post_count;
    logic                         trace_valid;
    logic [WORDSIZE-1:0]          trace_pc;
    logic [INSTRUCTION_SIZE-1:0]  trace_instr;
    logic [CHANNELS*WORDSIZE-1:0] trace_chan;
    logic                         trace_rd_ready;
    logic                         trace_rd_valid;
    logic [WORDSIZE-1:0]          trace_rd_pc;
    logic [INSTRUCTION_SIZE-1:0]  trace_rd_instr;
    logic [CHANNELS*WORDSIZE-1:0] trace_rd_chan;
    logic [1:0]                   trace_state;
    logic [CW-1:0]                trace_count;
    logic                         trace_overflow;

    modport master (
        output trace_arm, trace_mode, trace_trig_pc, trace_post_count, trace_valid,
               trace_pc, trace_instr, trace_chan, trace_rd_ready,
        input  trace_rd_valid, trace_rd_pc, trace_rd_instr, trace_rd_chan,
               trace_state, trace_count, trace_overflow
    );

    modport slave (
        input  trace_arm, trace_mode, trace_trig_pc, trace_post_count, trace_valid,
               trace_pc, trace_instr, trace_chan, trace_rd_ready,
        output trace_rd_valid, trace_rd_pc, trace_rd_instr, trace_rd_chan,
               trace_state, trace_count, trace_overflow
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: triggerable circular trace history, drained oldest-first
module cpu_trace_buffer #(
    parameter int WORDSIZE = 64,
    parameter int INSTRUCTION_SIZE = 32,
    parameter int CHANNELS = 6,
    parameter int DEPTH = 16,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input logic trace_clk,
    input logic trace_rst_n,
    cpu_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = WORDSIZE + INSTRUCTION_SIZE + CHANNELS * WORDSIZE;
    localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);
    localparam logic [CW-1:0] MAX_POST = CW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, remaining, rem_nx, post_clip;
    logic          overflow, we, trig, pop, rd_valid;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] rd_entry;

    assign we        = !bus.trace_arm && (state == ARMED || state == CAPTURE) && bus.trace_valid;
    assign trig      = we && state == ARMED && (bus.trace_mode || bus.trace_pc == bus.trace_trig_pc);
    assign post_clip = bus.trace_post_count > MAX_POST ? MAX_POST : bus.trace_post_count;
    assign rd_valid  = state == DONE && count != '0;
    assign pop       = !bus.trace_arm && rd_valid && bus.trace_rd_ready;
    // Oldest entry sits count slots behind the write pointer; a full buffer wraps to wr_ptr itself.
    assign rd_ptr    = wr_ptr - count[AW-1:0];
    assign rd_entry  = mem[rd_ptr];

    // Next state and post-trigger countdown; arm overrides everything.
    always_comb begin
        state_nx = state;
        rem_nx   = remaining;
        if (bus.trace_arm) begin
            state_nx = ARMED;
        end else if (trig) begin
            rem_nx   = post_clip;
            state_nx = post_clip == '0 ? DONE : CAPTURE;
        end else if (state == CAPTURE && we) begin
            rem_nx   = remaining - 1'b1;
            state_nx = remaining == CW'(1) ? DONE : CAPTURE;
        end else if (pop && count == CW'(1)) begin
            state_nx = IDLE;
        end
    end

    // State, pointers, occupancy and sticky overflow.
    always_ff @(posedge trace_clk or negedge trace_rst_n) begin
        if (!trace_rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nx;
            remaining <= rem_nx;
            if (bus.trace_arm) begin
                wr_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else if (we) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (count == DEPTH_CW) overflow <= 1'b1;
                else count <= count + 1'b1;
            end else if (pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage; contents survive reset and are only meaningful while counted.
    always_ff @(posedge trace_clk) begin
        if (we) mem[wr_ptr] <= {bus.trace_pc, bus.trace_instr, bus.trace_chan};
    end

    assign bus.trace_rd_valid = rd_valid;
    assign bus.trace_rd_pc    = rd_valid ? rd_entry[EW-1 -: WORDSIZE] : '0;
    assign bus.trace_rd_instr = rd_valid ? rd_entry[CHANNELS*WORDSIZE +: INSTRUCTION_SIZE] : '0;
    assign bus.trace_rd_chan  = rd_valid ? rd_entry[CHANNELS*WORDSIZE-1:0] : '0;
    assign bus.trace_state    = state;
    assign bus.trace_count    = count;
    assign bus.trace_overflow = overflow;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: queue-model checked random and directed trace scenarios
module tb_cpu_trace_buffer;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [63:0]  pc;
        logic [31:0]  instr;
        logic [383:0] chan;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    ent_t q[$];
    ent_t e;
    int   mstate = 0;
    int   mrem = 0;
    logic movf = 1'b0;
    logic [63:0] last_pc;

    cpu_trace_buffer_if bus ();

    cpu_trace_buffer dut (
        .trace_clk(clk),
        .trace_rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the buffer is a queue bounded to DEPTH, the front is what must be presented.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstate = 0;
            q.delete();
            movf = 1'b0;
            mrem = 0;
        end else if (bus.trace_arm) begin
            mstate = 1;
            q.delete();
            movf = 1'b0;
        end else if ((mstate == 1 || mstate == 2) && bus.trace_valid) begin
            e = '{bus.trace_pc, bus.trace_instr, bus.trace_chan};
            q.push_back(e);
            if (q.size() > DEPTH) begin
                void'(q.pop_front());
                movf = 1'b1;
            end
            if (mstate == 1) begin
                if (bus.trace_mode || bus.trace_pc == bus.trace_trig_pc) begin
                    mrem = bus.trace_post_count > DEPTH - 1 ? DEPTH - 1 : int'(bus.trace_post_count);
                    mstate = mrem == 0 ? 3 : 2;
                end
            end else begin
                mrem--;
                if (mrem == 0) mstate = 3;
            end
        end else if (mstate == 3 && q.size() != 0 && bus.trace_rd_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) mstate = 0;
        end
    end

    // Every cycle, away from the active edge, the DUT must agree with the queue model.
    always @(negedge clk) begin
        ent_t f;
        logic v;
        v = mstate == 3 && q.size() != 0;
        f = v ? q[0] : '0;
        check("state", 384'(bus.trace_state), 384'(mstate));
        check("count", 384'(bus.trace_count), 384'(q.size()));
        check("overflow", 384'(bus.trace_overflow), 384'(movf));
        check("rd_valid", 384'(bus.trace_rd_valid), 384'(v));
        check("rd_pc", 384'(bus.trace_rd_pc), 384'(f.pc));
        check("rd_instr", 384'(bus.trace_rd_instr), 384'(f.instr));
        check("rd_chan", bus.trace_rd_chan, f.chan);
    end

    task automatic arm(input logic mode, input logic [63:0] trig, input logic [4:0] post);
        bus.trace_mode = mode;
        bus.trace_trig_pc = trig;
        bus.trace_post_count = post;
        bus.trace_arm = 1'b1;
        tick();
        bus.trace_arm = 1'b0;
    endtask

    task automatic randomize_data();
        bus.trace_instr = $urandom;
        for (int k = 0; k < 6; k++) bus.trace_chan[k*64 +: 64] = {$urandom, $urandom};
    endtask

    task automatic sample(input logic [63:0] pc, input logic valid);
        bus.trace_pc = pc;
        randomize_data();
        bus.trace_valid = valid;
        tick();
        bus.trace_valid = 1'b0;
    endtask

    initial begin
        logic [383:0] held_chan;
        logic [31:0]  held_instr;
        bus.trace_arm = 1'b0;
        bus.trace_mode = 1'b0;
        bus.trace_trig_pc = '0;
        bus.trace_post_count = '0;
        bus.trace_valid = 1'b0;
        bus.trace_pc = '0;
        bus.trace_instr = '0;
        bus.trace_chan = '0;
        bus.trace_rd_ready = 1'b0;
        tick();
        tick();
        check("reset_state", 384'(bus.trace_state), 384'(0));
        check("reset_count", 384'(bus.trace_count), 384'(0));
        check("reset_rd_valid", 384'(bus.trace_rd_valid), 384'(0));
        rst_n = 1'b1;
        tick();

        // T1: immediate trigger, three post entries, drained in order
        arm(1'b1, 64'h0, 5'd3);
        for (int i = 0; i < 4; i++) sample(64'(i * 4), 1'b1);
        check("t1_state", 384'(bus.trace_state), 384'(3));
        check("t1_count", 384'(bus.trace_count), 384'(4));
        bus.trace_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t1_order", 384'(bus.trace_rd_pc), 384'(i * 4));
            tick();
        end
        bus.trace_rd_ready = 1'b0;
        check("t1_idle", 384'(bus.trace_state), 384'(0));
        check("t1_rd_valid", 384'(bus.trace_rd_valid), 384'(0));

        // T2: PC trigger after wrap-around
        arm(1'b0, 64'h40, 5'd3);
        for (int i = 0; i < 24; i++) sample(64'(i * 4), 1'b1);
        check("t2_overflow", 384'(bus.trace_overflow), 384'(1));
        check("t2_count", 384'(bus.trace_count), 384'(16));
        check("t2_first_pc", 384'(bus.trace_rd_pc), 384'(64'h10));

        // T3: back-pressure holds the presented entry
        held_chan = bus.trace_rd_chan;
        held_instr = bus.trace_rd_instr;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_valid", 384'(bus.trace_rd_valid), 384'(1));
            check("t3_pc", 384'(bus.trace_rd_pc), 384'(64'h10));
            check("t3_instr", 384'(bus.trace_rd_instr), 384'(held_instr));
            check("t3_chan", bus.trace_rd_chan, held_chan);
            check("t3_count", 384'(bus.trace_count), 384'(16));
        end
        bus.trace_rd_ready = 1'b1;
        tick();
        bus.trace_rd_ready = 1'b0;
        check("t3_pop_count", 384'(bus.trace_count), 384'(15));
        check("t3_next_pc", 384'(bus.trace_rd_pc), 384'(64'h14));
        bus.trace_rd_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            last_pc = bus.trace_rd_pc;
            tick();
        end
        bus.trace_rd_ready = 1'b0;
        check("t2_last_pc", 384'(last_pc), 384'(64'h4c));

        // T4: matching PC without valid does not trigger
        arm(1'b0, 64'h40, 5'd2);
        sample(64'h40, 1'b0);
        check("t4_state", 384'(bus.trace_state), 384'(1));
        check("t4_count", 384'(bus.trace_count), 384'(0));
        sample(64'h44, 1'b1);
        check("t4_state_b", 384'(bus.trace_state), 384'(1));
        check("t4_count_b", 384'(bus.trace_count), 384'(1));

        // T5: post count clipped to DEPTH-1 keeps the trigger entry
        arm(1'b1, 64'h0, 5'd20);
        for (int i = 0; i < 20; i++) sample(64'h100 + 64'(i * 4), 1'b1);
        check("t5_count", 384'(bus.trace_count), 384'(16));
        check("t5_overflow", 384'(bus.trace_overflow), 384'(0));
        check("t5_first_pc", 384'(bus.trace_rd_pc), 384'(64'h100));

        // T6: arm during DONE, then async reset mid-capture
        bus.trace_rd_ready = 1'b1;
        tick();
        tick();
        bus.trace_rd_ready = 1'b0;
        check("t6_count_2pops", 384'(bus.trace_count), 384'(14));
        arm(1'b1, 64'h0, 5'd5);
        check("t6_arm_state", 384'(bus.trace_state), 384'(1));
        check("t6_arm_count", 384'(bus.trace_count), 384'(0));
        check("t6_arm_rd_valid", 384'(bus.trace_rd_valid), 384'(0));
        for (int i = 0; i < 3; i++) sample(64'h200 + 64'(i * 4), 1'b1);
        check("t6_capture", 384'(bus.trace_state), 384'(2));
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_state", 384'(bus.trace_state), 384'(0));
        check("t6_rst_count", 384'(bus.trace_count), 384'(0));
        rst_n = 1'b1;
        tick();

        // Random traffic against the queue model
        for (int n = 0; n < 4000; n++) begin
            bus.trace_arm = $urandom_range(0, 39) == 0;
            bus.trace_mode = 1'($urandom_range(0, 1));
            bus.trace_trig_pc = 64'h40 + 64'($urandom_range(0, 2) * 4);
            bus.trace_post_count = 5'($urandom_range(0, 20));
            bus.trace_valid = $urandom_range(0, 9) < 7;
            bus.trace_pc = 64'h40 + 64'($urandom_range(0, 7) * 4);
            bus.trace_rd_ready = $urandom_range(0, 9) < 6;
            randomize_data();
            tick();
            if ($urandom_range(0, 399) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
